// File: rtl/mem_pkg.sv
// Shared types for the MEM stage: access-size encodings, FSM states and the
// MEM/WB register layout.
package mem_pkg;

   localparam logic [3:0] DT_WORD = 4'b0001;
   localparam logic [3:0] DT_HALF = 4'b0010;
   localparam logic [3:0] DT_BYTE = 4'b0100;

   typedef enum logic {
      IDLE,
      WAIT_RD
   } mem_state_e;

   typedef struct packed {
      logic        rf_wena;
      logic [4:0]  rf_waddr;
      logic [31:0] rf_wdata;
      logic        hi_ena;
      logic [31:0] hi_idata;
      logic        lo_ena;
      logic [31:0] lo_idata;
      logic        exc;
   } wb_t;

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: store byte-enables / lane replication and
// load-data extraction with optional sign extension.
module mem_align
   import mem_pkg::*;
(
   input  logic [2:0]  data_type,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] store_data,
   input  logic [31:0] rdata,
   input  logic        cbw_sign,
   input  logic        chw_sign,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] load_data
);

   logic        is_word;
   logic        is_half;
   logic        is_byte;
   logic [15:0] half_sel;
   logic [7:0]  byte_sel;

   // Word wins over half wins over byte if more than one size bit is set.
   always_comb begin
      is_word  = |(data_type & DT_WORD[2:0]);
      is_half  = ~is_word & |(data_type & DT_HALF[2:0]);
      is_byte  = ~is_word & ~is_half & |(data_type & DT_BYTE[2:0]);
      half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      case (addr_lo)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase

      be        = 4'b1111;
      wdata     = store_data;
      load_data = rdata;
      if (is_half) begin
         be        = addr_lo[1] ? 4'b1100 : 4'b0011;
         wdata     = {2{store_data[15:0]}};
         load_data = {{16{chw_sign & half_sel[15]}}, half_sel};
      end else if (is_byte) begin
         be        = 4'b0001 << addr_lo;
         wdata     = {4{store_data[7:0]}};
         load_data = {{24{cbw_sign & byte_sel[7]}}, byte_sel};
      end
   end

endmodule

// File: rtl/mem_stage_unit.sv
// MIPS MEM stage: data-bus handshake FSM, MEM/WB register and upstream stall.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses via w_exc.
module mem_stage_unit
   import mem_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        em_dmem_wena,
   input  logic [3:0]  em_data_type,
   input  logic        em_cbw_sign,
   input  logic        em_chw_sign,
   input  logic        em_mux_rf_dmem,
   input  logic [31:0] em_rf_rdata2,
   input  logic        em_rf_wena,
   input  logic [4:0]  em_rf_waddr,
   input  logic        em_hi_ena,
   input  logic [31:0] em_hi_idata,
   input  logic        em_lo_ena,
   input  logic [31:0] em_lo_idata,
   input  logic [31:0] em_alu_out,
   input  logic [31:0] em_exe_out,
   output logic        mem_stall,
   output logic        dm_req,
   output logic        dm_we,
   output logic [31:0] dm_addr,
   output logic [3:0]  dm_be,
   output logic [31:0] dm_wdata,
   input  logic        dm_gnt,
   input  logic        dm_rvalid,
   input  logic [31:0] dm_rdata,
   output logic        w_rf_wena,
   output logic [4:0]  w_rf_waddr,
   output logic [31:0] w_rf_wdata,
   output logic        w_hi_ena,
   output logic [31:0] w_hi_idata,
   output logic        w_lo_ena,
   output logic [31:0] w_lo_idata,
   output logic        w_exc
);

   mem_state_e  state_q, state_d;
   wb_t         wb_q, wb_d;
   logic        is_load, is_store, access, misalign, bus_access, complete;
   logic [31:0] load_data;
   logic        unused_dt3;

   assign unused_dt3 = em_data_type[3];

   mem_align u_align (
      .data_type  (em_data_type[2:0]),
      .addr_lo    (em_alu_out[1:0]),
      .store_data (em_rf_rdata2),
      .rdata      (dm_rdata),
      .cbw_sign   (em_cbw_sign),
      .chw_sign   (em_chw_sign),
      .be         (dm_be),
      .wdata      (dm_wdata),
      .load_data  (load_data)
   );

   // Bus outputs are gated by rst so a reset mid-access drops dm_req at once.
   always_comb begin
      is_store = em_dmem_wena;
      is_load  = em_mux_rf_dmem & |em_data_type[2:0] & ~is_store;
      access   = is_load | is_store;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign = em_data_type[0] ? |em_alu_out[1:0] : (em_data_type[1] & em_alu_out[0]);
`else
      misalign = 1'b0;
`endif
      bus_access = access & ~misalign & ~rst;
      state_d    = state_q;
      complete   = 1'b0;
      dm_req     = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus_access) begin
               dm_req = 1'b1;
               if (dm_gnt) begin
                  if (is_store) complete = 1'b1;
                  else          state_d  = WAIT_RD;
               end
            end
         end
         WAIT_RD: begin
            if (dm_rvalid) begin
               complete = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      mem_stall = bus_access & ~complete;
      dm_we     = dm_req & is_store;
   end

   // A stall or trap writes a bubble: enables cleared, payload held.
   always_comb begin
      wb_d         = wb_q;
      wb_d.rf_wena = 1'b0;
      wb_d.hi_ena  = 1'b0;
      wb_d.lo_ena  = 1'b0;
      wb_d.exc     = 1'b0;
      if (mem_stall) begin
         wb_d.exc = 1'b0;
      end else if (access & misalign) begin
         wb_d.exc = 1'b1;
      end else begin
         wb_d.rf_wena  = em_rf_wena;
         wb_d.rf_waddr = em_rf_waddr;
         wb_d.rf_wdata = is_load ? load_data : em_exe_out;
         wb_d.hi_ena   = em_hi_ena;
         wb_d.hi_idata = em_hi_idata;
         wb_d.lo_ena   = em_lo_ena;
         wb_d.lo_idata = em_lo_idata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         wb_q    <= '0;
      end else begin
         state_q <= state_d;
         wb_q    <= wb_d;
      end
   end

   assign dm_addr    = {em_alu_out[31:2], 2'b00};
   assign w_rf_wena  = wb_q.rf_wena;
   assign w_rf_waddr = wb_q.rf_waddr;
   assign w_rf_wdata = wb_q.rf_wdata;
   assign w_hi_ena   = wb_q.hi_ena;
   assign w_hi_idata = wb_q.hi_idata;
   assign w_lo_ena   = wb_q.lo_ena;
   assign w_lo_idata = wb_q.lo_idata;
   assign w_exc      = wb_q.exc;

endmodule
